// File: rtl/rgb_fade_sequencer_if.sv
// Palette write port of the RGB fade sequencer.
// The master drives one entry per strobe; the slave owns the palette.
interface rgb_fade_sequencer_if #(
  parameter int IW     = 2,
  parameter int HOLD_W = 8
);
  logic              wr_en;
  logic [IW-1:0]     wr_addr;
  logic [23:0]       wr_color;
  logic [HOLD_W-1:0] wr_hold;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_color,
    output wr_hold
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_color,
    input wr_hold
  );
endinterface

// File: rtl/rgb_fade_sequencer.sv
// Palette walker that fades the PWM colour towards each entry,
// holds it, then advances; all sequencing runs on the PWM sync edge.
module rgb_fade_sequencer #(
  parameter int  ENTRIES = 4,
  parameter int  HOLD_W  = 8,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sync_i,
  input  logic                  run,
  input  logic [7:0]            fade_step,
  input  logic [IW-1:0]         last_idx,
  rgb_fade_sequencer_if.slave   wr,
  output logic [7:0]            rcolor_o,
  output logic [7:0]            gcolor_o,
  output logic [7:0]            bcolor_o,
  output logic [IW-1:0]         idx_o,
  output logic [1:0]            state_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [23:0]       col_q, col_d;
  logic [23:0]       tgt_q, tgt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              done_q, done_d;
  logic              sync_q;
  logic              tick;

  logic [23:0]       pal_c_q [ENTRIES];
  logic [HOLD_W-1:0] pal_h_q [ENTRIES];

  logic [23:0]       nxt_col;
  logic [IW-1:0]     nxt_idx;
  logic              wrap;

  assign tick = sync_i & ~sync_q;

  // 9-bit distance so a step never wraps past the target
  function automatic logic [7:0] fade_ch(
    input logic [7:0] cur,
    input logic [7:0] tgt,
    input logic [7:0] step
  );
    logic [8:0] diff;
    if (cur >= tgt) diff = {1'b0, cur} - {1'b0, tgt};
    else            diff = {1'b0, tgt} - {1'b0, cur};
    if (step == 8'd0 || diff <= {1'b0, step}) begin
      return tgt;
    end else if (cur < tgt) begin
      return cur + step;
    end else begin
      return cur - step;
    end
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        pal_c_q[i] <= '0;
        pal_h_q[i] <= '0;
      end
    end else if (wr.wr_en) begin
      pal_c_q[wr.wr_addr] <= wr.wr_color;
      pal_h_q[wr.wr_addr] <= wr.wr_hold;
    end
  end

  assign nxt_col = {
    fade_ch(col_q[23:16], tgt_q[23:16], fade_step),
    fade_ch(col_q[15:8],  tgt_q[15:8],  fade_step),
    fade_ch(col_q[7:0],   tgt_q[7:0],   fade_step)
  };

  assign wrap    = (idx_q >= last_idx);
  assign nxt_idx = wrap ? '0 : idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    col_d   = col_q;
    tgt_d   = tgt_q;
    hold_d  = hold_q;
    done_d  = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (run) begin
            tgt_d   = pal_c_q[idx_q];
            state_d = FADE;
          end
        end
        FADE: begin
          if (!run) begin
            state_d = IDLE;
          end else begin
            col_d = nxt_col;
            if (nxt_col == tgt_q) begin
              state_d = HOLD;
              hold_d  = pal_h_q[idx_q];
            end
          end
        end
        HOLD: begin
          if (!run) begin
            state_d = IDLE;
            hold_d  = '0;
          end else if (hold_q != '0) begin
            hold_d = hold_q - 1'b1;
          end else begin
            idx_d   = nxt_idx;
            tgt_d   = pal_c_q[nxt_idx];
            state_d = FADE;
            done_d  = wrap;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      col_q   <= '0;
      tgt_q   <= '0;
      hold_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      col_q   <= col_d;
      tgt_q   <= tgt_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
    end
  end

  assign rcolor_o = col_q[23:16];
  assign gcolor_o = col_q[15:8];
  assign bcolor_o = col_q[7:0];
  assign idx_o    = idx_q;
  assign state_o  = state_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Scoreboard bench for rgb_fade_sequencer: a tick-level model
// pushes expectations, the DUT outputs are popped and compared.
module tb_rgb_fade_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sync_i;
  logic       run;
  logic [7:0] fade_step;
  logic [1:0] last_idx;
  logic [7:0] rcolor_o, gcolor_o, bcolor_o;
  logic [1:0] idx_o;
  logic [1:0] state_o;
  logic       done_o;

  rgb_fade_sequencer_if #(.IW(2), .HOLD_W(8)) bus ();

  rgb_fade_sequencer #(.ENTRIES(4), .HOLD_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sync_i    (sync_i),
    .run       (run),
    .fade_step (fade_step),
    .last_idx  (last_idx),
    .wr        (bus),
    .rcolor_o  (rcolor_o),
    .gcolor_o  (gcolor_o),
    .bcolor_o  (bcolor_o),
    .idx_o     (idx_o),
    .state_o   (state_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  idx;
    logic [23:0] col;
    logic        done;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;

  int m_st, m_idx, m_hold;
  int m_col [3];
  int m_tgt [3];
  int m_pal_c [4];
  int m_pal_h [4];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int chan(input int c, input int ch);
    return (c >> (16 - 8 * ch)) & 255;
  endfunction

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_hold = 0;
    for (int i = 0; i < 3; i++) begin
      m_col[i] = 0;
      m_tgt[i] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      m_pal_c[i] = 0;
      m_pal_h[i] = 0;
    end
  endtask

  task automatic load_tgt();
    for (int i = 0; i < 3; i++) m_tgt[i] = chan(m_pal_c[m_idx], i);
  endtask

  task automatic model_tick();
    exp_t e;
    bit   dn = 0;
    bit   eq;
    int   st = fade_step;
    case (m_st)
      0: if (run) begin load_tgt(); m_st = 1; end
      1: begin
        if (!run) m_st = 0;
        else begin
          eq = 1;
          for (int i = 0; i < 3; i++) begin
            int d = m_col[i] - m_tgt[i];
            if (d < 0) d = -d;
            if (st == 0 || d <= st) m_col[i] = m_tgt[i];
            else if (m_col[i] < m_tgt[i]) m_col[i] += st;
            else m_col[i] -= st;
            if (m_col[i] != m_tgt[i]) eq = 0;
          end
          if (eq) begin
            m_st = 2;
            m_hold = m_pal_h[m_idx];
          end
        end
      end
      default: begin
        if (!run) begin m_st = 0; m_hold = 0; end
        else if (m_hold > 0) m_hold--;
        else begin
          if (m_idx >= int'(last_idx)) begin m_idx = 0; dn = 1; end
          else m_idx++;
          load_tgt();
          m_st = 1;
        end
      end
    endcase
    e.st   = 2'(m_st);
    e.idx  = 2'(m_idx);
    e.col  = 24'((m_col[0] << 16) | (m_col[1] << 8) | m_col[2]);
    e.done = dn;
    sb.push_back(e);
    e.done = 1'b0;
    sb.push_back(e);
  endtask

  task automatic cmp_pop(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_st"},   32'(state_o), 32'(e.st));
    chk({tag, "_idx"},  32'(idx_o),   32'(e.idx));
    chk({tag, "_rgb"},  {8'h0, rcolor_o, gcolor_o, bcolor_o}, 32'(e.col));
    chk({tag, "_done"}, 32'(done_o),  32'(e.done));
  endtask

  // one sync pulse per 4 clks, held high for hi clks
  task automatic pulse(input int hi);
    @(negedge clk);
    sync_i = 1'b1;
    model_tick();
    @(posedge clk);
    #1;
    cmp_pop("tick");
    repeat (hi) @(negedge clk);
    sync_i = 1'b0;
    repeat (4 - hi - 1) @(negedge clk);
    cmp_pop("held");
  endtask

  task automatic pal_wr(input int a, input int c, input int h);
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 2'(a);
    bus.wr_color = 24'(c);
    bus.wr_hold  = 8'(h);
    @(negedge clk);
    bus.wr_en = 1'b0;
    m_pal_c[a] = c;
    m_pal_h[a] = h;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_st",   32'(state_o), 32'd0);
    chk("rst_idx",  32'(idx_o),   32'd0);
    chk("rst_rgb",  {8'h0, rcolor_o, gcolor_o, bcolor_o}, 32'd0);
    chk("rst_done", 32'(done_o),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int t4_exp [4] = '{32'hBF, 32'h7F, 32'h3F, 32'h03};

  initial begin
    rst = 1'b0; sync_i = 1'b0; run = 1'b0;
    fade_step = 8'd0; last_idx = 2'd0;
    bus.wr_en = 1'b0; bus.wr_addr = '0;
    bus.wr_color = '0; bus.wr_hold = '0;
    do_reset();

    // slow fade up to one entry, hold, wrap onto itself
    pal_wr(0, 24'h1000FF, 2);
    fade_step = 8'h08; last_idx = 2'd0; run = 1'b1;
    for (int i = 1; i <= 38; i++) begin
      pulse(1 + (i % 3));
      if (i == 2)  chk("t2_r08", 32'(rcolor_o), 32'h08);
      if (i == 32) chk("t2_bF8", 32'(bcolor_o), 32'hF8);
      if (i == 33) chk("t2_hold", 32'(state_o), 32'd2);
      if (i == 36) chk("t2_wrap", 32'(state_o), 32'd1);
      if (i == 37) chk("t2_refade", 32'(state_o), 32'd2);
    end

    // reset in HOLD clears palette; fade to 0 is immediate
    do_reset();
    pulse(2);
    pulse(2);
    chk("t6_hold", 32'(state_o), 32'd2);

    // jumps through three entries, held sync gives one tick
    do_reset();
    pal_wr(0, 24'hFF0000, 0);
    pal_wr(1, 24'h00FF00, 0);
    pal_wr(2, 24'h0000FF, 0);
    fade_step = 8'd0; last_idx = 2'd2; run = 1'b1;
    for (int i = 0; i < 14; i++) pulse(3);
    last_idx = 2'd0;
    for (int i = 0; i < 6; i++) pulse($urandom_range(3, 1));

    // fade down without underflow
    do_reset();
    pal_wr(0, 24'hFFFFFF, 0);
    pal_wr(1, 24'h030303, 0);
    fade_step = 8'd0; last_idx = 2'd1; run = 1'b1;
    pulse(1);
    pulse(1);
    fade_step = 8'h40;
    pulse(1);
    for (int i = 0; i < 4; i++) begin
      pulse(2);
      chk("t4_red", 32'(rcolor_o), 32'(t4_exp[i]));
    end

    // pause mid-fade, resume from frozen colour
    do_reset();
    pal_wr(0, 24'h804020, 1);
    fade_step = 8'h10; last_idx = 2'd0; run = 1'b1;
    pulse(1); pulse(1); pulse(1);
    run = 1'b0;
    pulse(1);
    chk("t5_idle", 32'(state_o), 32'd0);
    chk("t5_frz", 32'(rcolor_o), 32'h20);
    pulse(2);
    run = 1'b1;
    pulse(1);
    pulse(1);
    chk("t5_r30", 32'(rcolor_o), 32'h30);
    chk("t5_b20", 32'(bcolor_o), 32'h20);
    for (int i = 0; i < 8; i++) pulse(2);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
